conv3x3_engine: RTL and testbench

Parametrised 3x3 fixed-point convolution engine; second-generation image-convolution block of the HW/SW co-design lab.
- Loads nine signed Q(32-FRAC_BITS).FRAC_BITS kernel coefficients from memory at run time.
- Convolves an IMG_W x IMG_H image (valid region only) and writes the (IMG_W-2) x (IMG_H-2) result back.
- Sits between the PS-visible BRAM port (1-cycle read latency) and the control register that drives `ready`.
- Reruns on each new `ready` handshake, with no reset needed between frames.

---
 rtl/conv3x3_engine.sv | 213 +++++++++++++++++++++
 tb/tb_conv3x3_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// 3x3 fixed-point convolution over an IMG_W x IMG_H image (valid region), reading
// coefficients and pixels through a 1-cycle-latency BRAM port. Define CONV_RELU_EN for ReLU on writes.
module conv3x3_engine #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int FRAC_BITS = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              R_req,
    output logic [ADDR_W-1:0] R_addr,
    input  logic [31:0]       R_data,
    output logic [3:0]        W_req,
    output logic [ADDR_W-1:0] W_addr,
    output logic [31:0]       W_data,
    output logic              busy,
    output logic              done
);

    localparam int XW = $clog2(IMG_W) + 1;
    localparam int YW = $clog2(IMG_H) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_K = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state;
    logic [3:0]        c;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] ker_base_q;
    logic [ADDR_W-1:0] img_base_q;
    logic [ADDR_W-1:0] out_base_q;
    logic [31:0]       k [0:8];
    logic [31:0]       acc;

    logic [1:0]        kr;
    logic [1:0]        kc;
    logic              slot_issue;
    logic              slot_capture;
    logic              last_slot;
    logic              last_pix;
    logic [3:0]        t_idx;
    logic [ADDR_W-1:0] pix_idx;
    logic [ADDR_W-1:0] out_idx;
    logic [ADDR_W-1:0] ker_addr;
    logic [ADDR_W-1:0] img_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic signed [63:0] k_ext;
    logic signed [63:0] d_ext;
    logic signed [63:0] prod;
    logic [31:0]       prod_q;
    logic [31:0]       acc_nxt;
    logic [31:0]       wr_data;

    // Window row/column of the tap whose address is issued in slot c.
    always_comb begin
        kr = 2'd0;
        kc = 2'd0;
        case (c)
            4'd1: kc = 2'd1;
            4'd2: kc = 2'd2;
            4'd3: kr = 2'd1;
            4'd4: begin kr = 2'd1; kc = 2'd1; end
            4'd5: begin kr = 2'd1; kc = 2'd2; end
            4'd6: kr = 2'd2;
            4'd7: begin kr = 2'd2; kc = 2'd1; end
            4'd8: begin kr = 2'd2; kc = 2'd2; end
            default: begin kr = 2'd0; kc = 2'd0; end
        endcase
    end

    always_comb begin
        slot_issue   = (c <= 4'd8);
        slot_capture = (c >= 4'd2);
        last_slot    = (c == 4'd10);
        last_pix     = (x == X_LAST) && (y == Y_LAST);
        t_idx        = slot_capture ? (c - 4'd2) : 4'd0;

        pix_idx  = (ADDR_W'(y) + ADDR_W'(kr) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                 + ADDR_W'(x) + ADDR_W'(kc) - ADDR_W'(1);
        out_idx  = (ADDR_W'(y) - ADDR_W'(1)) * ADDR_W'(IMG_W - 2)
                 + ADDR_W'(x) - ADDR_W'(1);
        ker_addr = ker_base_q + ADDR_W'({c, 2'b00});
        img_addr = img_base_q + (pix_idx << 2);
        wr_addr  = out_base_q + (out_idx << 2);

        // Full-precision product; the Q-format result is the 32-bit slice above FRAC_BITS.
        k_ext   = 64'($signed(k[t_idx]));
        d_ext   = 64'($signed(R_data));
        prod    = k_ext * d_ext;
        prod_q  = 32'(prod >>> FRAC_BITS);
        acc_nxt = ((t_idx == 4'd0) ? 32'd0 : acc) + prod_q;

`ifdef CONV_RELU_EN
        wr_data = acc[31] ? 32'd0 : acc;
`else
        wr_data = acc;
`endif
    end

    assign busy = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            c          <= '0;
            x          <= XW'(1);
            y          <= YW'(1);
            ker_base_q <= '0;
            img_base_q <= '0;
            out_base_q <= '0;
            acc        <= '0;
            for (int unsigned i = 0; i < 9; i++) begin
                k[i] <= '0;
            end
            R_req      <= 1'b0;
            R_addr     <= '0;
            W_req      <= '0;
            W_addr     <= '0;
            W_data     <= '0;
            done       <= 1'b0;
        end else begin
            R_req <= 1'b0;
            R_addr <= '0;
            W_req <= '0;
            done  <= (state == DONE) && ready;

            case (state)
                IDLE: begin
                    c <= '0;
                    if (ready) begin
                        ker_base_q <= ker_base;
                        img_base_q <= img_base;
                        out_base_q <= out_base;
                        x          <= XW'(1);
                        y          <= YW'(1);
                        state      <= LOAD_K;
                    end
                end
                LOAD_K: begin
                    if (slot_issue) begin
                        R_req  <= 1'b1;
                        R_addr <= ker_addr;
                    end
                    if (slot_capture) begin
                        k[t_idx] <= R_data;
                    end
                    if (last_slot) begin
                        c     <= '0;
                        state <= READ;
                    end else begin
                        c <= c + 4'd1;
                    end
                end
                READ: begin
                    if (slot_issue) begin
                        R_req  <= 1'b1;
                        R_addr <= img_addr;
                    end
                    if (slot_capture) begin
                        acc <= acc_nxt;
                    end
                    if (last_slot) begin
                        c     <= '0;
                        state <= WRITE;
                    end else begin
                        c <= c + 4'd1;
                    end
                end
                WRITE: begin
                    W_req  <= 4'b1111;
                    W_addr <= wr_addr;
                    W_data <= wr_data;
                    c      <= '0;
                    if (last_pix) begin
                        x     <= XW'(1);
                        y     <= YW'(1);
                        state <= DONE;
                    end else begin
                        if (x == X_LAST) begin
                            x <= XW'(1);
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                        state <= READ;
                    end
                end
                DONE: begin
                    c <= '0;
                    if (!ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    c     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine on a 5x4 image: table of frames with hand-computed
// results, plus sequences for read timing, ready hold/restart and mid-frame reset.
module tb_conv3x3_engine;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NOUT = (W - 2) * (H - 2);
    localparam int NVEC = 6;
`ifdef CONV_RELU_EN
    localparam logic [31:0] NEG_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_EXP = 32'hFFFE_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] ker_base = '0;
    logic [31:0] img_base = '0;
    logic [31:0] out_base = '0;
    logic        R_req;
    logic [31:0] R_addr;
    logic [31:0] R_data;
    logic [3:0]  W_req;
    logic [31:0] W_addr;
    logic [31:0] W_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    conv3x3_engine #(.IMG_W(W), .IMG_H(H), .FRAC_BITS(16), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .ker_base(ker_base), .img_base(img_base), .out_base(out_base),
        .R_req(R_req), .R_addr(R_addr), .R_data(R_data),
        .W_req(W_req), .W_addr(W_addr), .W_data(W_data),
        .busy(busy), .done(done)
    );

    logic [31:0] mem [0:255];
    always @(posedge clk) R_data <= R_req ? mem[R_addr[9:2]] : 32'h5A5A_5A5A;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  req;
        int          rel;
    } wr_t;

    typedef struct {
        logic [31:0]            kb;
        logic [31:0]            ib;
        logic [31:0]            ob;
        int                     ksel;
        int                     isel;
        logic [NOUT-1:0][31:0]  exp;
    } vec_t;

    wr_t         wq[$];
    vec_t        vecs[NVEC];
    int          checks = 0;
    int          errors = 0;
    int          t0 = 0;
    int          rel = 0;
    int          wbase = 0;
    int          done_rel = -1;
    logic        rq [0:127];
    logic [31:0] ra [0:127];
    logic        bz [0:127];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, expv);
        end
    endtask

    // One cycle: advance to the falling edge and log outputs against the frame's cycle 0.
    task automatic step();
        wr_t e;
        @(negedge clk);
        rel = cyc - t0;
        if (W_req != 4'b0000) begin
            e.addr = W_addr;
            e.data = W_data;
            e.req  = W_req;
            e.rel  = rel;
            wq.push_back(e);
        end
        if (rel >= 0 && rel < 128) begin
            rq[rel] = R_req;
            ra[rel] = R_addr;
            bz[rel] = busy;
        end
    endtask

    function automatic logic [31:0] kval(input int ksel, input int t);
        case (ksel)
            0: return (t == 4) ? 32'h0001_0000 : 32'h0;
            1: return 32'h0000_8000;
            2: return (t == 4) ? 32'hFFFF_0000 : 32'h0;
            3: return 32'h0001_0000;
            4: return 32'(t + 1) << 16;
            default: return (t == 0) ? 32'hFFFF_8000 : ((t == 8) ? 32'h0002_0000 : 32'h0);
        endcase
    endfunction

    function automatic logic [31:0] pval(input int isel, input int i);
        case (isel)
            0: return 32'(i) << 16;
            1: return 32'h0001_0000;
            2: return 32'h0002_0000;
            default: return 32'h7FFF_0000;
        endcase
    endfunction

    function automatic vec_t mk(input logic [31:0] kb, input logic [31:0] ib, input logic [31:0] ob,
                                input int ksel, input int isel,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5);
        vec_t v;
        v.kb = kb; v.ib = ib; v.ob = ob; v.ksel = ksel; v.isel = isel;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
        return v;
    endfunction

    task automatic begin_frame(input vec_t v);
        step();
        ready = 1'b0;
        step();
        chk("done_clear", {31'b0, done}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        for (int t = 0; t < 9; t++) mem[int'(v.kb[9:2]) + t] = kval(v.ksel, t);
        for (int i = 0; i < W * H; i++) mem[int'(v.ib[9:2]) + i] = pval(v.isel, i);
        ker_base = v.kb;
        img_base = v.ib;
        out_base = v.ob;
        ready    = 1'b1;
        @(posedge clk);
        #1;
        t0       = cyc - 1;
        wbase    = wq.size();
        done_rel = -1;
        step();
        // Base changes while busy must not reach the frame.
        ker_base = 32'h0000_0300;
        img_base = 32'h0000_0380;
        out_base = 32'hFFFF_0000;
    endtask

    task automatic finish_frame(input vec_t v, input int idx);
        int  n;
        wr_t e;
        for (int i = 0; i < 300 && done_rel < 0; i++) begin
            step();
            if (done) done_rel = rel;
        end
        chk($sformatf("v%0d done_seen", idx), {31'b0, done}, 32'd1);
        chk($sformatf("v%0d done_cycle", idx), done_rel, 32'd85);
        repeat (20) step();
        chk($sformatf("v%0d done_held", idx), {31'b0, done}, 32'd1);
        n = wq.size() - wbase;
        chk($sformatf("v%0d write_count", idx), n, NOUT);
        for (int j = 0; j < NOUT; j++) begin
            if (wbase + j < wq.size()) begin
                e = wq[wbase + j];
                chk($sformatf("v%0d w%0d addr", idx, j), e.addr, v.ob + 32'(4 * j));
                chk($sformatf("v%0d w%0d data", idx, j), e.data, v.exp[j]);
                chk($sformatf("v%0d w%0d cycle", idx, j), e.rel, 32'(24 + 12 * j));
                chk($sformatf("v%0d w%0d req", idx, j), {28'b0, e.req}, 32'hF);
            end
        end
    endtask

    initial begin
        vecs[0] = mk(32'h040, 32'h200, 32'h1000, 0, 0,
                     32'h0006_0000, 32'h0007_0000, 32'h0008_0000,
                     32'h000B_0000, 32'h000C_0000, 32'h000D_0000);
        vecs[1] = mk(32'h080, 32'h280, 32'h2000, 1, 1,
                     32'h0004_8000, 32'h0004_8000, 32'h0004_8000,
                     32'h0004_8000, 32'h0004_8000, 32'h0004_8000);
        vecs[2] = mk(32'h0C0, 32'h200, 32'h3000, 2, 2,
                     NEG_EXP, NEG_EXP, NEG_EXP, NEG_EXP, NEG_EXP, NEG_EXP);
        vecs[3] = mk(32'h100, 32'h280, 32'h4000, 3, 3,
                     32'h7FF7_0000, 32'h7FF7_0000, 32'h7FF7_0000,
                     32'h7FF7_0000, 32'h7FF7_0000, 32'h7FF7_0000);
        vecs[4] = mk(32'h140, 32'h200, 32'h5000, 4, 0,
                     32'h016E_0000, 32'h019B_0000, 32'h01C8_0000,
                     32'h024F_0000, 32'h027C_0000, 32'h02A9_0000);
        vecs[5] = mk(32'h180, 32'h280, 32'h6000, 5, 0,
                     32'h0018_0000, 32'h0019_8000, 32'h001B_0000,
                     32'h001F_8000, 32'h0021_0000, 32'h0022_8000);

        repeat (3) @(negedge clk);
        chk("rst R_req", {31'b0, R_req}, 32'd0);
        chk("rst R_addr", R_addr, 32'd0);
        chk("rst W_req", {28'b0, W_req}, 32'd0);
        chk("rst W_addr", W_addr, 32'd0);
        chk("rst W_data", W_data, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            begin_frame(vecs[v]);
            finish_frame(vecs[v], v);
            if (v == 0) begin
                chk("busy c1", {31'b0, bz[1]}, 32'd1);
                chk("busy c23", {31'b0, bz[23]}, 32'd1);
                chk("rreq c1", {31'b0, rq[1]}, 32'd0);
                chk("rreq c2", {31'b0, rq[2]}, 32'd1);
                chk("raddr c2", ra[2], vecs[0].kb);
                chk("raddr c10", ra[10], vecs[0].kb + 32'd32);
                chk("rreq c11", {31'b0, rq[11]}, 32'd0);
                chk("raddr c11", ra[11], 32'd0);
                chk("rreq c13", {31'b0, rq[13]}, 32'd1);
                chk("raddr c13", ra[13], vecs[0].ib);
                chk("raddr c21", ra[21], vecs[0].ib + 32'd48);
                chk("rreq c22", {31'b0, rq[22]}, 32'd0);
                chk("raddr c25", ra[25], vecs[0].ib + 32'd4);
            end
        end

        begin_frame(vecs[4]);
        while (rel < 30) step();
        chk("pre_reset W_addr", W_addr, vecs[4].ob);
        rst_n = 1'b0;
        #1;
        chk("midrst R_req", {31'b0, R_req}, 32'd0);
        chk("midrst R_addr", R_addr, 32'd0);
        chk("midrst W_req", {28'b0, W_req}, 32'd0);
        chk("midrst W_addr", W_addr, 32'd0);
        chk("midrst W_data", W_data, 32'd0);
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);
        ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        begin_frame(vecs[4]);
        finish_frame(vecs[4], 6);

        step();
        ready = 1'b0;
        step();
        chk("final done_clear", {31'b0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
